// File: rtl/usb_gpx_pkg.sv
// Shared types and constants for the USB GPX pin conditioner.
// Holds the filter FSM state encoding and the edge-select bit masks.
package usb_gpx_pkg;

   typedef enum logic [1:0] {
      S_LOW    = 2'd0,
      S_RISE_Q = 2'd1,
      S_HIGH   = 2'd2,
      S_FALL_Q = 2'd3
   } gpx_state_t;

   localparam logic [1:0] EDGE_RISE = 2'b01;
   localparam logic [1:0] EDGE_FALL = 2'b10;

endpackage

// File: rtl/gpx_sync2.sv
// Generic 2-FF synchronizer for a single asynchronous input.
// Ports: clk, reset (sync, active-high), d (async in), q (synchronized out, resets to 0).
module gpx_sync2 (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/usb_gpx_conditioner.sv
// Conditions the async GPX pin: 2-FF sync, consecutive-sample glitch filter,
// edge events, sticky flag and saturating event counter.
// Ports: clk, reset (sync, active-high), gpx_in (raw pin), clr_evt (clear strobe),
//        gpx_level (filtered level), evt_pulse, evt_sticky, evt_count[CNT_W-1:0].
module usb_gpx_conditioner
   import usb_gpx_pkg::*;
#(
   parameter int         FILTER_CYCLES = 4,
   parameter int         CNT_W         = 16,
   parameter logic [1:0] EDGE_SEL      = 2'b01
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             gpx_in,
   input  logic             clr_evt,
   output logic             gpx_level,
   output logic             evt_pulse,
   output logic             evt_sticky,
   output logic [CNT_W-1:0] evt_count
);

   localparam int QW = $clog2(FILTER_CYCLES + 1);
   localparam logic [QW-1:0] QMAX = QW'(FILTER_CYCLES);
   localparam logic [QW-1:0] QONE = QW'(1);

   localparam logic CNT_RISE = (EDGE_SEL & EDGE_RISE) != 2'b00;
   localparam logic CNT_FALL = (EDGE_SEL & EDGE_FALL) != 2'b00;

   logic          sync2;
   gpx_state_t    state;
   gpx_state_t    state_nxt;
   logic [QW-1:0] qual_cnt;
   logic [QW-1:0] qual_nxt;
   logic          rise_acc;
   logic          fall_acc;
   logic          evt_set;
   logic          level_nxt;

   gpx_sync2 u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (gpx_in),
      .q     (sync2)
   );

   // qual_cnt counts consecutive samples at the new level; a sample at
   // the old level during qualification drops straight back.
   always_comb begin
      state_nxt = state;
      qual_nxt  = qual_cnt;
      rise_acc  = 1'b0;
      fall_acc  = 1'b0;
      unique case (state)
         S_LOW: begin
            if (sync2) begin
               qual_nxt = QONE;
               if (FILTER_CYCLES == 1) begin
                  state_nxt = S_HIGH;
                  rise_acc  = 1'b1;
               end else begin
                  state_nxt = S_RISE_Q;
               end
            end
         end
         S_RISE_Q: begin
            if (!sync2) begin
               state_nxt = S_LOW;
               qual_nxt  = '0;
            end else begin
               qual_nxt = qual_cnt + QONE;
               if (qual_cnt + QONE == QMAX) begin
                  state_nxt = S_HIGH;
                  rise_acc  = 1'b1;
               end
            end
         end
         S_HIGH: begin
            if (!sync2) begin
               qual_nxt = QONE;
               if (FILTER_CYCLES == 1) begin
                  state_nxt = S_LOW;
                  fall_acc  = 1'b1;
               end else begin
                  state_nxt = S_FALL_Q;
               end
            end
         end
         S_FALL_Q: begin
            if (sync2) begin
               state_nxt = S_HIGH;
               qual_nxt  = '0;
            end else begin
               qual_nxt = qual_cnt + QONE;
               if (qual_cnt + QONE == QMAX) begin
                  state_nxt = S_LOW;
                  fall_acc  = 1'b1;
               end
            end
         end
         default: begin
            state_nxt = S_LOW;
            qual_nxt  = '0;
         end
      endcase
   end

   assign evt_set   = (rise_acc & CNT_RISE) | (fall_acc & CNT_FALL);
   assign level_nxt = (state_nxt == S_HIGH) || (state_nxt == S_FALL_Q);

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_LOW;
         qual_cnt  <= '0;
         gpx_level <= 1'b0;
         evt_pulse <= 1'b0;
      end else begin
         state     <= state_nxt;
         qual_cnt  <= qual_nxt;
         gpx_level <= level_nxt;
         evt_pulse <= evt_set;
      end
   end

   // A new event beats a coincident clear, so it is never lost.
   always_ff @(posedge clk) begin
      if (reset) begin
         evt_sticky <= 1'b0;
         evt_count  <= '0;
      end else begin
         if (evt_set) begin
            evt_sticky <= 1'b1;
         end else if (clr_evt) begin
            evt_sticky <= 1'b0;
         end
         if (clr_evt) begin
            evt_count <= evt_set ? CNT_W'(1) : '0;
         end else if (evt_set && (evt_count != '1)) begin
            evt_count <= evt_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_usb_gpx_conditioner.sv
// Directed self-checking bench for usb_gpx_conditioner.
// Three instances share stimulus: default, both-edge, and 4-bit both-edge counter.
module tb_usb_gpx_conditioner;
   import usb_gpx_pkg::*;

   logic clk = 1'b0;
   logic reset;
   logic gpx_in;
   logic clr_evt;

   logic        lvl_d, pul_d, stk_d;
   logic [15:0] cnt_d;
   logic        lvl_b, pul_b, stk_b;
   logic [15:0] cnt_b;
   logic        lvl_s, pul_s, stk_s;
   logic [3:0]  cnt_s;

   int compared   = 0;
   int mismatched = 0;
   int np_d = 0;
   int np_b = 0;
   int np_s = 0;
   logic seen_d = 1'b0;

   always #5 clk = ~clk;

   usb_gpx_conditioner u_def (
      .clk        (clk),
      .reset      (reset),
      .gpx_in     (gpx_in),
      .clr_evt    (clr_evt),
      .gpx_level  (lvl_d),
      .evt_pulse  (pul_d),
      .evt_sticky (stk_d),
      .evt_count  (cnt_d)
   );

   usb_gpx_conditioner #(.EDGE_SEL(2'b11)) u_both (
      .clk        (clk),
      .reset      (reset),
      .gpx_in     (gpx_in),
      .clr_evt    (clr_evt),
      .gpx_level  (lvl_b),
      .evt_pulse  (pul_b),
      .evt_sticky (stk_b),
      .evt_count  (cnt_b)
   );

   usb_gpx_conditioner #(.CNT_W(4), .EDGE_SEL(2'b11)) u_sat (
      .clk        (clk),
      .reset      (reset),
      .gpx_in     (gpx_in),
      .clr_evt    (clr_evt),
      .gpx_level  (lvl_s),
      .evt_pulse  (pul_s),
      .evt_sticky (stk_s),
      .evt_count  (cnt_s)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance n edges, sampling 1 time unit after each edge.
   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         np_d += int'(pul_d);
         np_b += int'(pul_b);
         np_s += int'(pul_s);
         seen_d |= lvl_d;
      end
   endtask

   task automatic clear_all();
      np_d = 0;
      np_b = 0;
      np_s = 0;
      seen_d = 1'b0;
   endtask

   task automatic pulse(input int hi, input int lo);
      gpx_in = 1'b1;
      cyc(hi);
      gpx_in = 1'b0;
      cyc(lo);
   endtask

   task automatic strobe_clr();
      clr_evt = 1'b1;
      cyc(1);
      clr_evt = 1'b0;
   endtask

   initial begin
      int glen [3];
      glen[0] = 1;
      glen[1] = 2;
      glen[2] = 3;

      reset   = 1'b1;
      gpx_in  = 1'b0;
      clr_evt = 1'b0;
      cyc(20);
      chk("rst_level", 32'(lvl_d), 32'd0);
      chk("rst_pulse", 32'(pul_d), 32'd0);
      chk("rst_sticky", 32'(stk_d), 32'd0);
      chk("rst_count", 32'(cnt_d), 32'd0);
      chk("rst_state", 32'(u_def.state), 32'(S_LOW));
      reset = 1'b0;
      cyc(2);

      gpx_in = 1'b1;
      cyc(5);
      chk("rise_lvl_e5", 32'(lvl_d), 32'd0);
      chk("rise_pul_e5", 32'(pul_d), 32'd0);
      cyc(1);
      chk("rise_lvl_e6", 32'(lvl_d), 32'd1);
      chk("rise_pul_e6", 32'(pul_d), 32'd1);
      chk("rise_cnt", 32'(cnt_d), 32'd1);
      chk("rise_stk", 32'(stk_d), 32'd1);
      cyc(1);
      chk("rise_pul_e7", 32'(pul_d), 32'd0);
      chk("rise_lvl_e7", 32'(lvl_d), 32'd1);

      gpx_in = 1'b0;
      cyc(6);
      chk("fall_lvl", 32'(lvl_d), 32'd0);
      chk("fall_pul_def", 32'(pul_d), 32'd0);
      chk("fall_pul_both", 32'(pul_b), 32'd1);
      chk("fall_cnt_def", 32'(cnt_d), 32'd1);
      chk("fall_cnt_both", 32'(cnt_b), 32'd2);
      cyc(2);
      strobe_clr();
      chk("clr1_cnt_def", 32'(cnt_d), 32'd0);
      chk("clr1_stk_def", 32'(stk_d), 32'd0);
      chk("clr1_cnt_both", 32'(cnt_b), 32'd0);

      foreach (glen[i]) begin
         clear_all();
         pulse(glen[i], 10);
         chk($sformatf("glitch%0d_lvl", glen[i]), 32'(seen_d), 32'd0);
         chk($sformatf("glitch%0d_evt", glen[i]), 32'(np_b), 32'd0);
      end
      chk("glitch_cnt", 32'(cnt_b), 32'd0);

      clear_all();
      pulse(5, 12);
      chk("g5_seen", 32'(seen_d), 32'd1);
      chk("g5_lvl", 32'(lvl_d), 32'd0);
      chk("g5_np_def", 32'(np_d), 32'd1);
      chk("g5_cnt_def", 32'(cnt_d), 32'd1);
      chk("g5_cnt_both", 32'(cnt_b), 32'd2);
      strobe_clr();

      clear_all();
      repeat (3) pulse(8, 8);
      chk("p3_np_both", 32'(np_b), 32'd6);
      chk("p3_cnt_both", 32'(cnt_b), 32'd6);
      chk("p3_cnt_def", 32'(cnt_d), 32'd3);
      strobe_clr();
      chk("p3_clr_cnt", 32'(cnt_b), 32'd0);
      chk("p3_clr_stk", 32'(stk_b), 32'd0);

      gpx_in = 1'b1;
      cyc(5);
      clr_evt = 1'b1;
      cyc(1);
      clr_evt = 1'b0;
      chk("coin_pul", 32'(pul_b), 32'd1);
      chk("coin_cnt_both", 32'(cnt_b), 32'd1);
      chk("coin_stk_both", 32'(stk_b), 32'd1);
      chk("coin_cnt_def", 32'(cnt_d), 32'd1);
      chk("coin_stk_def", 32'(stk_d), 32'd1);
      gpx_in = 1'b0;
      cyc(8);
      chk("coin_fall_both", 32'(cnt_b), 32'd2);
      chk("coin_fall_sat", 32'(cnt_s), 32'd2);

      strobe_clr();
      repeat (10) pulse(8, 8);
      chk("sat_cnt", 32'(cnt_s), 32'd15);
      chk("sat_stk", 32'(stk_s), 32'd1);
      chk("sat_cnt_both", 32'(cnt_b), 32'd20);
      chk("sat_cnt_def", 32'(cnt_d), 32'd10);

      gpx_in = 1'b1;
      cyc(4);
      chk("mid_state", 32'(u_def.state), 32'(S_RISE_Q));
      chk("mid_qual", 32'(u_def.qual_cnt), 32'd2);
      reset = 1'b1;
      cyc(1);
      chk("mrst_lvl", 32'(lvl_d), 32'd0);
      chk("mrst_pul", 32'(pul_d), 32'd0);
      chk("mrst_stk", 32'(stk_d), 32'd0);
      chk("mrst_cnt", 32'(cnt_d), 32'd0);
      chk("mrst_state", 32'(u_def.state), 32'(S_LOW));
      cyc(2);
      reset = 1'b0;
      cyc(5);
      chk("rel_lvl_e5", 32'(lvl_d), 32'd0);
      cyc(1);
      chk("rel_lvl_e6", 32'(lvl_d), 32'd1);
      chk("rel_pul_e6", 32'(pul_d), 32'd1);
      chk("rel_cnt", 32'(cnt_d), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule
